cordic_vector: RTL and testbench

Iterative CORDIC vectoring-mode engine that converts a signed Cartesian sample (x, y) into gain-compensated magnitude and phase. It is the inverse of the rotation-mode sine/cosine generator. It shares that block's angle format: 16-bit unsigned phase, full circle = 2^16, 0x4000 = 90°, top two bits = quadrant. It sits on the receive/measurement side, for example phase detection of the generator's output, and uses a start/busy/done handshake.

---
 rtl/cordic_vector_if.sv | 16 +
 rtl/cordic_vector.sv | 118 +++++++++++
 tb/tb_cordic_vector.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cordic_vector_if.sv
// Start/busy/done handshake and data bundle for the CORDIC vectoring engine.
interface cordic_vector_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         start;
    logic signed [DATA_WIDTH-1:0] x_in;
    logic signed [DATA_WIDTH-1:0] y_in;
    logic                         busy;
    logic                         done;
    logic [DATA_WIDTH:0]          mag_out;
    logic [15:0]                  phase_out;

    // start is sampled only while busy=0; done is a one-cycle pulse marking mag_out/phase_out valid.
    modport master (output start, x_in, y_in, input busy, done, mag_out, phase_out);
    modport slave  (input start, x_in, y_in, output busy, done, mag_out, phase_out);
endinterface

// File: rtl/cordic_vector.sv
// Iterative CORDIC vectoring engine: (x, y) to gain-compensated magnitude and 16-bit phase.
// A result takes 18 clocks: one capture, 16 micro-rotations and one scale/output cycle.
module cordic_vector #(
    parameter int DATA_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    cordic_vector_if.slave    bus,
    output logic [1:0]        state_dbg
);
    localparam int XW = DATA_WIDTH + 2;
    localparam int PW = DATA_WIDTH + 18;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ITER  = 2'd1;
    localparam logic [1:0] SCALE = 2'd2;

    logic [1:0]           state;
    logic signed [XW-1:0] xr, yr;
    logic signed [16:0]   zr;
    logic [3:0]           iter;
    logic                 zero_flag;

    logic signed [XW-1:0] x_ext, y_ext, x_sh, y_sh;
    logic signed [16:0]   atan_i;
    logic [PW-1:0]        prod;

    function automatic logic [15:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_lut = 16'h2000;
            4'd1:    atan_lut = 16'h12E4;
            4'd2:    atan_lut = 16'h09FB;
            4'd3:    atan_lut = 16'h0511;
            4'd4:    atan_lut = 16'h028B;
            4'd5:    atan_lut = 16'h0145;
            4'd6:    atan_lut = 16'h00A3;
            4'd7:    atan_lut = 16'h0051;
            4'd8:    atan_lut = 16'h0028;
            4'd9:    atan_lut = 16'h0014;
            4'd10:   atan_lut = 16'h000A;
            4'd11:   atan_lut = 16'h0005;
            4'd12:   atan_lut = 16'h0003;
            4'd13:   atan_lut = 16'h0001;
            4'd14:   atan_lut = 16'h0001;
            default: atan_lut = 16'h0000;
        endcase
    endfunction

    always_comb begin
        x_ext  = {{2{bus.x_in[DATA_WIDTH-1]}}, bus.x_in};
        y_ext  = {{2{bus.y_in[DATA_WIDTH-1]}}, bus.y_in};
        x_sh   = xr >>> iter;
        y_sh   = yr >>> iter;
        atan_i = {1'b0, atan_lut(iter)};
        // x stays non-negative after pre-rotation, so an unsigned product is safe.
        prod   = {{(PW-XW){1'b0}}, xr} * {{(PW-16){1'b0}}, 16'h9B74};
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            xr            <= '0;
            yr            <= '0;
            zr            <= '0;
            iter          <= '0;
            zero_flag     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.mag_out   <= '0;
            bus.phase_out <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Fold the left half-plane onto the right by a 180 degree pre-rotation.
                        if (bus.x_in[DATA_WIDTH-1]) begin
                            xr <= -x_ext;
                            yr <= -y_ext;
                            zr <= 17'sh08000;
                        end else begin
                            xr <= x_ext;
                            yr <= y_ext;
                            zr <= '0;
                        end
                        zero_flag <= (bus.x_in == '0) && (bus.y_in == '0);
                        iter      <= '0;
                        bus.busy  <= 1'b1;
                        state     <= ITER;
                    end
                end
                ITER: begin
                    if (!yr[XW-1]) begin
                        xr <= xr + y_sh;
                        yr <= yr - x_sh;
                        zr <= zr + atan_i;
                    end else begin
                        xr <= xr - y_sh;
                        yr <= yr + x_sh;
                        zr <= zr - atan_i;
                    end
                    iter <= iter + 4'd1;
                    if (iter == 4'd15) state <= SCALE;
                end
                SCALE: begin
                    bus.mag_out   <= zero_flag ? '0 : prod[DATA_WIDTH+16:16];
                    bus.phase_out <= zero_flag ? '0 : zr[15:0];
                    bus.done      <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_vector.sv
// Directed scoreboard bench for cordic_vector: expected results queued at issue, checked on done.
module tb_cordic_vector;
    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;

    cordic_vector_if #(.DATA_WIDTH(16)) vif ();

    cordic_vector #(.DATA_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (vif.slave),
        .state_dbg (state_dbg)
    );

    // entry = {mag_tol[3:0], phase_tol[3:0], mag[16:0], phase[15:0]}
    logic [40:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int n_done = 0;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input bit ok, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && vif.done) begin
            logic [40:0] e;
            logic [15:0] dpu;
            int dm, dp;
            n_done++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1'b0, 1, 0);
            end else begin
                e   = exp_q.pop_front();
                dm  = int'(vif.mag_out) - int'(e[32:16]);
                dpu = vif.phase_out - e[15:0];
                dp  = int'($signed(dpu));
                chk("mag", (dm <= int'(e[40:37])) && (-dm <= int'(e[40:37])),
                    longint'(vif.mag_out), longint'(e[32:16]));
                chk("phase", (dp <= int'(e[36:33])) && (-dp <= int'(e[36:33])),
                    longint'(vif.phase_out), longint'(e[15:0]));
            end
        end
    end

    // driver: one operation with exact latency checks
    task automatic run_op(input logic signed [15:0] x, input logic signed [15:0] y,
                          input logic [16:0] m, input logic [15:0] p,
                          input logic [3:0] tm, input logic [3:0] tp);
        bit early;
        early = 1'b0;
        exp_q.push_back({tm, tp, m, p});
        vif.start = 1'b1;
        vif.x_in  = x;
        vif.y_in  = y;
        @(posedge clk);
        #1;
        vif.start = 1'b0;
        vif.x_in  = 16'(16'h5A5A);
        vif.y_in  = 16'(16'hA5A5);
        chk("busy_after_accept", vif.busy == 1'b1, longint'(vif.busy), 1);
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            if (k < 17 && vif.done) early = 1'b1;
        end
        chk("done_not_early", !early, longint'(early), 0);
        chk("done_at_n17", vif.done == 1'b1, longint'(vif.done), 1);
        chk("busy_low_at_n17", vif.busy == 1'b0, longint'(vif.busy), 0);
        @(posedge clk);
        #1;
        chk("done_fall_n18", vif.done == 1'b0, longint'(vif.done), 0);
    endtask

    task automatic wait_dones(input int target, input int budget);
        int c;
        c = 0;
        while (n_done < target && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk("done_count", n_done >= target, longint'(n_done), longint'(target));
    endtask

    initial begin
        vif.start = 1'b0;
        vif.x_in  = '0;
        vif.y_in  = '0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", vif.busy == 1'b0, longint'(vif.busy), 0);
        chk("rst_done", vif.done == 1'b0, longint'(vif.done), 0);
        chk("rst_mag", vif.mag_out == '0, longint'(vif.mag_out), 0);
        chk("rst_phase", vif.phase_out == '0, longint'(vif.phase_out), 0);
        chk("rst_state", state_dbg == 2'd0, longint'(state_dbg), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(16'sd16384, 16'sd0, 17'd16384, 16'h0000, 4'd4, 4'd3);
        run_op(16'sd0, 16'sd16384, 17'd16384, 16'h4000, 4'd4, 4'd3);
        run_op(16'sd0, -16'sd16384, 17'd16384, 16'hC000, 4'd4, 4'd3);
        run_op(-16'sd16384, -16'sd16384, 17'd23170, 16'hA000, 4'd4, 4'd3);
        run_op(-16'sd16384, 16'sd16384, 17'd23170, 16'h6000, 4'd4, 4'd3);
        run_op(-16'sd32768, 16'sd0, 17'd32768, 16'h8000, 4'd4, 4'd3);
        run_op(-16'sd32768, -16'sd32768, 17'd46341, 16'hA000, 4'd4, 4'd3);
        run_op(16'sd0, 16'sd0, 17'd0, 16'h0000, 4'd0, 4'd0);
        run_op(16'sd23170, 16'sd23170, 17'd32767, 16'h2000, 4'd4, 4'd3);

        // stray start 5 clocks into an operation is ignored
        exp_q.push_back({4'd4, 4'd3, 17'd16384, 16'hC000});
        vif.start = 1'b1;
        vif.x_in  = 16'sd0;
        vif.y_in  = -16'sd16384;
        @(posedge clk);
        #1;
        vif.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vif.start = 1'b1;
        vif.x_in  = 16'sd16384;
        vif.y_in  = 16'sd0;
        @(posedge clk);
        #1;
        vif.start = 1'b0;
        wait_dones(n_done + 1, 40);
        repeat (25) @(posedge clk);
        #1;
        chk("single_done_q_empty", exp_q.size() == 0, longint'(exp_q.size()), 0);

        // reset at iteration 8 aborts without a done pulse
        vif.start = 1'b1;
        vif.x_in  = 16'sd16384;
        vif.y_in  = 16'sd16384;
        @(posedge clk);
        #1;
        vif.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", vif.busy == 1'b0, longint'(vif.busy), 0);
        chk("abort_done", vif.done == 1'b0, longint'(vif.done), 0);
        chk("abort_mag", vif.mag_out == '0, longint'(vif.mag_out), 0);
        chk("abort_phase", vif.phase_out == '0, longint'(vif.phase_out), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk("abort_state_idle", state_dbg == 2'd0, longint'(state_dbg), 0);

        run_op(16'sd16384, 16'sd16384, 17'd23170, 16'h2000, 4'd4, 4'd3);

        // start held high: back-to-back results every 18 clocks
        exp_q.push_back({4'd4, 4'd3, 17'd16384, 16'h4000});
        exp_q.push_back({4'd4, 4'd3, 17'd16384, 16'h8000});
        vif.start = 1'b1;
        vif.x_in  = 16'sd0;
        vif.y_in  = 16'sd16384;
        @(posedge clk);
        #1;
        vif.x_in = -16'sd16384;
        vif.y_in = 16'sd0;
        repeat (18) @(posedge clk);
        #1;
        vif.start = 1'b0;
        chk("b2b_second_busy", vif.busy == 1'b1, longint'(vif.busy), 1);
        wait_dones(n_done + 1, 40);
        repeat (3) @(posedge clk);
        #1;
        chk("final_q_empty", exp_q.size() == 0, longint'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
